// File: rtl/seg_display_scanner.sv
`default_nettype none
// ============================================================================
// Module  : seg_display_scanner
// Brief   : Time-multiplexed driver for a 4-digit common-anode seven-segment
//           display. Shows a 4-character window onto the 6-character string
//           {sign, D4..D0}. Leading zeros are blanked. The window is scrolled by
//           single-cycle button pulses.
// Revision: 1.0  initial release
// ============================================================================
module seg_display_scanner #(
  parameter int REFRESH_DIV = 100000   // cycles each physical digit stays lit (>= 2)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] D0,
  input  logic [4:0] D1,
  input  logic [4:0] D2,
  input  logic [4:0] D3,
  input  logic [4:0] D4,
  input  logic       neg,
  input  logic       scroll_left,
  input  logic       scroll_right,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int             CNT_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [1:0]     W_MAX    = 2'd2;
  localparam logic [6:0]     SEG_BLANK = 7'b1111111;
  localparam logic [6:0]     SEG_MINUS = 7'b0111111;

  // Active-low {g..a} pattern of one BCD value; non-decimal codes show blank.
  function automatic logic [6:0] enc_digit(input logic [3:0] v);
    case (v)
      4'd0:    enc_digit = 7'b1000000;
      4'd1:    enc_digit = 7'b1111001;
      4'd2:    enc_digit = 7'b0100100;
      4'd3:    enc_digit = 7'b0110000;
      4'd4:    enc_digit = 7'b0011001;
      4'd5:    enc_digit = 7'b0010010;
      4'd6:    enc_digit = 7'b0000010;
      4'd7:    enc_digit = 7'b1111000;
      4'd8:    enc_digit = 7'b0000000;
      4'd9:    enc_digit = 7'b0010000;
      default: enc_digit = SEG_BLANK;
    endcase
  endfunction

  // State and registered outputs.
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       scan_q, scan_d;
  logic [1:0]       w_q, w_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  // Bit 4 of each digit input carries no information for the display.
  logic unused_digit_msbs;
  assign unused_digit_msbs = ^{D0[4], D1[4], D2[4], D3[4], D4[4]};

  // Leading-zero blanking: a position is blank when it and every more
  // significant digit position are zero. P0 is excluded so "0" still shows.
  logic [4:1] is_zero;
  logic [4:1] lz_blank;
  assign is_zero[1] = (D1[3:0] == 4'd0);
  assign is_zero[2] = (D2[3:0] == 4'd0);
  assign is_zero[3] = (D3[3:0] == 4'd0);
  assign is_zero[4] = (D4[3:0] == 4'd0);
  assign lz_blank[4] = is_zero[4];
  assign lz_blank[3] = is_zero[3] & lz_blank[4];
  assign lz_blank[2] = is_zero[2] & lz_blank[3];
  assign lz_blank[1] = is_zero[1] & lz_blank[2];

  // Refresh counter, scan index and window offset next-state.
  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    scan_d = scan_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      scan_d = scan_q + 2'd1;
    end
    w_d = w_q;
    if (scroll_left && !scroll_right && (w_q != W_MAX)) begin
      w_d = w_q + 2'd1;
    end else if (scroll_right && !scroll_left && (w_q != 2'd0)) begin
      w_d = w_q - 2'd1;
    end
  end

  // Character for the currently scanned digit: position P(w + scan).
  logic [2:0] pos_sel;
  always_comb begin
    pos_sel = 3'(w_q) + 3'(scan_q);
    seg_d   = SEG_BLANK;
    case (pos_sel)
      3'd0: seg_d = enc_digit(D0[3:0]);
      3'd1: seg_d = lz_blank[1] ? SEG_BLANK : enc_digit(D1[3:0]);
      3'd2: seg_d = lz_blank[2] ? SEG_BLANK : enc_digit(D2[3:0]);
      3'd3: seg_d = lz_blank[3] ? SEG_BLANK : enc_digit(D3[3:0]);
      3'd4: seg_d = lz_blank[4] ? SEG_BLANK : enc_digit(D4[3:0]);
      3'd5: seg_d = neg ? SEG_MINUS : SEG_BLANK;
      default: seg_d = SEG_BLANK;
    endcase
    an_d = ~(4'b0001 << scan_q);
    // Decimal point on the rightmost digit flags a scrolled window.
    dp_d = !((scan_q == 2'd0) && (w_q != 2'd0));
  end

  // All state and outputs update together; reset clears everything at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      scan_q <= 2'd0;
      w_q    <= 2'd0;
      an_q   <= 4'b1111;
      seg_q  <= SEG_BLANK;
      dp_q   <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      scan_q <= scan_d;
      w_q    <= w_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_scanner.sv
`default_nettype none
// ============================================================================
// Module  : tb_seg_display_scanner
// Brief   : Self-checking bench for seg_display_scanner (REFRESH_DIV = 4).
// Revision: 1.0  initial release
// ============================================================================
module tb_seg_display_scanner;

  localparam int REFRESH_DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] D0, D1, D2, D3, D4;
  logic       neg, scroll_left, scroll_right;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  int m_cnt, m_scan, m_w;
  logic [11:0] sb [$];

  localparam logic [6:0] ENC [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                      7'b0000000, 7'b0010000};
  localparam logic [6:0] BLK = 7'b1111111;
  localparam logic [6:0] MIN = 7'b0111111;

  seg_display_scanner #(.REFRESH_DIV(REFRESH_DIV)) dut (
    .clk(clk), .rst(rst),
    .D0(D0), .D1(D1), .D2(D2), .D3(D3), .D4(D4),
    .neg(neg), .scroll_left(scroll_left), .scroll_right(scroll_right),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Expected {an, seg, dp} from model state and current inputs.
  function automatic logic [11:0] model_out();
    logic [3:0] p [0:4];
    int m, pos;
    logic [6:0] s;
    logic [3:0] a;
    p[0] = D0[3:0]; p[1] = D1[3:0]; p[2] = D2[3:0]; p[3] = D3[3:0]; p[4] = D4[3:0];
    m = 0;
    for (int i = 1; i <= 4; i++) if (p[i] != 4'd0) m = i;
    pos = m_w + m_scan;
    if (pos == 5)                       s = neg ? MIN : BLK;
    else if (p[pos] > 4'd9)             s = BLK;
    else if (pos > m && p[pos] == 4'd0) s = BLK;
    else                                s = ENC[p[pos]];
    a = 4'b1111;
    a[m_scan] = 1'b0;
    return {a, s, (m_scan == 0 && m_w != 0) ? 1'b0 : 1'b1};
  endfunction

  // One clock: push expectation, advance model, then pop and compare.
  task automatic tick();
    logic [11:0] e, got;
    if (rst) sb.push_back({4'b1111, BLK, 1'b1});
    else     sb.push_back(model_out());
    if (rst) begin
      m_cnt = 0; m_scan = 0; m_w = 0;
    end else begin
      if (m_cnt == REFRESH_DIV - 1) begin
        m_cnt = 0; m_scan = (m_scan + 1) % 4;
      end else m_cnt++;
      if (scroll_left && !scroll_right && m_w < 2)      m_w++;
      else if (scroll_right && !scroll_left && m_w > 0) m_w--;
    end
    @(posedge clk); #1;
    got = {an, seg, dp};
    e = sb.pop_front();
    n_tests++;
    assert (got === e) else begin
      n_fail++;
      $error("FAIL scoreboard: {an,seg,dp} got %b expected %b", got, e);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_an(input string tag, input logic [3:0] exp_an);
    n_tests++;
    assert (an === exp_an) else begin
      n_fail++;
      $error("FAIL %s: an got %b expected %b", tag, an, exp_an);
    end
  endtask

  task automatic chk(input string tag, input logic [6:0] exp_seg, input logic exp_dp);
    n_tests++;
    assert ({seg, dp} === {exp_seg, exp_dp}) else begin
      n_fail++;
      $error("FAIL %s: seg/dp got %b/%b expected %b/%b", tag, seg, dp, exp_seg, exp_dp);
    end
  endtask

  // Tick until physical digit k is lit (bounded), then confirm it is.
  task automatic wait_digit(input int k);
    logic [3:0] tgt;
    tgt = 4'b1111;
    tgt[k] = 1'b0;
    tick();
    for (int i = 0; i < 12 && an !== tgt; i++) tick();
    chk_an($sformatf("wait_digit%0d", k), tgt);
  endtask

  task automatic pulse(input bit left, input bit right);
    scroll_left = left; scroll_right = right;
    tick();
    scroll_left = 1'b0; scroll_right = 1'b0;
  endtask

  task automatic set_digits(input logic [4:0] d4, d3, d2, d1, d0, input logic n);
    D4 = d4; D3 = d3; D2 = d2; D1 = d1; D0 = d0; neg = n;
  endtask

  initial begin
    rst = 1'b1; scroll_left = 1'b0; scroll_right = 1'b0;
    set_digits(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    m_cnt = 0; m_scan = 0; m_w = 0;

    // 1. Reset state and scan order
    ticks(3);
    chk_an("reset_an", 4'b1111);
    chk("reset_segdp", BLK, 1'b1);
    rst = 1'b0;
    tick(); chk_an("scan_first", 4'b1110);
    ticks(3); chk_an("scan_hold0", 4'b1110);
    tick(); chk_an("scan_1", 4'b1101);
    ticks(4); chk_an("scan_2", 4'b1011);
    ticks(4); chk_an("scan_3", 4'b0111);
    ticks(4); chk_an("scan_wrap", 4'b1110);

    // 2. Leading zeros blanked, no scroll
    set_digits(5'd0, 5'd0, 5'd1, 5'd2, 5'd3, 1'b0);
    wait_digit(0); chk("t2_d0", ENC[3], 1'b1);
    wait_digit(1); chk("t2_d1", ENC[2], 1'b1);
    wait_digit(2); chk("t2_d2", ENC[1], 1'b1);
    wait_digit(3); chk("t2_d3", BLK, 1'b1);

    // 3. Scroll left twice, with sign shown
    set_digits(5'd1, 5'd6, 5'd3, 5'd8, 5'd4, 1'b1);
    pulse(1'b1, 1'b0);
    tick();
    pulse(1'b1, 1'b0);
    wait_digit(0); chk("t3_d0", ENC[3], 1'b0);
    wait_digit(1); chk("t3_d1", ENC[6], 1'b1);
    wait_digit(2); chk("t3_d2", ENC[1], 1'b1);
    wait_digit(3); chk("t3_d3", MIN, 1'b1);
    pulse(1'b1, 1'b0);
    wait_digit(0); chk("t3_sat", ENC[3], 1'b0);

    // 4. Simultaneous pulses do nothing; scroll right saturates at 0
    pulse(1'b1, 1'b1);
    wait_digit(0); chk("t4_both", ENC[3], 1'b0);
    pulse(1'b0, 1'b1);
    tick();
    pulse(1'b0, 1'b1);
    tick();
    pulse(1'b0, 1'b1);
    wait_digit(0); chk("t4_w0_d0", ENC[4], 1'b1);
    wait_digit(1); chk("t4_w0_d1", ENC[8], 1'b1);
    wait_digit(3); chk("t4_w0_d3", ENC[6], 1'b1);

    // 5. All zero shows "   0"; non-decimal and bit-4 handling
    set_digits(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    wait_digit(0); chk("t5_zero_d0", ENC[0], 1'b1);
    wait_digit(1); chk("t5_zero_d1", BLK, 1'b1);
    wait_digit(2); chk("t5_zero_d2", BLK, 1'b1);
    wait_digit(3); chk("t5_zero_d3", BLK, 1'b1);
    D2 = 5'b01010;
    wait_digit(1); chk("t5_d2ten_d1", ENC[0], 1'b1);
    wait_digit(2); chk("t5_d2ten_d2", BLK, 1'b1);
    D2 = 5'b10101;
    wait_digit(1); chk("t5_bit4_d1", ENC[0], 1'b1);
    wait_digit(2); chk("t5_bit4_d2", ENC[5], 1'b1);

    // 6. Reset mid-scan with window scrolled
    D0 = 5'd7;
    pulse(1'b1, 1'b0);
    wait_digit(1);
    tick();
    rst = 1'b1;
    tick();
    chk_an("t6_rst_an", 4'b1111);
    chk("t6_rst_segdp", BLK, 1'b1);
    rst = 1'b0;
    tick();
    chk_an("t6_restart_an", 4'b1110);
    chk("t6_restart_w0", ENC[7], 1'b1);
    wait_digit(1); chk("t6_d1", ENC[0], 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg_display_scanner.md
Name: seg_display_scanner

Overview:
- Downstream stage of the binary-to-BCD converter in the signed multiplier on Basys 3.
- Takes five BCD digits plus the product sign and drives the 4-digit common-anode seven-segment display by time multiplexing.
- A 6-character virtual string (sign, D4..D0) is shown through a 4-character window, scrolled by single-cycle button pulses.
- Leading zeros are blanked.

Parameters:
- REFRESH_DIV, 100000: clock cycles each physical digit stays lit (1 ms at 100 MHz); legal values are 2 and above.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- D0, D1, D2, D3, D4  input  5 each  BCD digits, D0 least significant; bit 4 ignored; [3:0] values 10-15 display blank
- neg  input  1  product is negative
- scroll_left  input  1  single-cycle pulse (debounced upstream); shift window toward more significant positions
- scroll_right  input  1  single-cycle pulse; shift window toward less significant positions
- an  output  4  digit anodes, active-low, an[0] is the rightmost digit
- seg  output  7  {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low

Behaviour:
- Reset values (clk edge with rst=1): an=4'b1111, seg=7'b1111111, dp=1, refresh counter=0, scan index=0, window offset w=0.
  - Reset mid-scan or mid-scroll aborts immediately; no partial state is kept.
- Refresh counter: counts 0..REFRESH_DIV-1, then wraps to 0.
  - On the cycle it wraps, scan index advances 0→1→2→3→0.
- Virtual positions:
  - P0..P4 = D0..D4.
  - P5 = sign character: minus when neg=1, else blank.
- Window offset w ∈ {0,1,2}. Physical digit k (0..3) shows position P(w+k).
- Scrolling:
  - scroll_left alone: w=w+1, saturating at 2.
  - scroll_right alone: w=w-1, saturating at 0.
  - Both asserted in the same cycle: no change.
  - Scroll takes effect on the next clock edge. It does not reset the refresh counter or the scan index.
- Leading-zero blanking:
  - Let m = the highest index 1..4 with nonzero Pm[3:0]; m = 0 if none.
  - Positions P1..P4 above m that hold 0 display blank.
  - P0 is never blanked by this rule, so value 0 shows "0".
  - The sign (P5) is unaffected by this rule.
- Character encoding (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - minus=0111111, blank=1111111
- Outputs an, seg and dp are registered and recomputed every clock from the current scan index, w, and inputs.
  - Latency from any input or state change to outputs is 1 clock.
  - an is active-low one-hot of the scan index; exactly one bit is low at any time after the first post-reset edge.
- dp:
  - 0 (lit) only while scan index=0 and w≠0, marking that the window is scrolled.
  - 1 otherwise.
- Input digits are not latched. Changes appear on the next output update, with no tearing within a single clock.

Test Plan (REFRESH_DIV=4 in simulation):
1. Hold rst=1 for 3 cycles → an=1111, seg=1111111, dp=1. Release rst → an=1110 on the first edge; an steps 1101, 1011, 0111 every 4 cycles, then wraps to 1110.
2. D4..D0=0,0,1,2,3, neg=0, w=0 → scanning an[0..3] gives seg 0110000 (3), 0100100 (2), 1111001 (1), 1111111 (blank); dp=1 throughout.
3. D4..D0=1,6,3,8,4, neg=1; pulse scroll_left twice → w=2; digits 0..3 show 3, 6, 1, minus; dp=0 only while an=1110. A third scroll_left pulse leaves w=2.
4. w=2; assert scroll_left and scroll_right in the same cycle → w stays 2. Then 3 pulses of scroll_right → w=0, and dp stays 1.
5. All digits 0, neg=0 → displays "   0": an[0] gives seg 1000000, others blank. Set D2[3:0]=10 → digit 2 blank; D2 with bit 4=1 and [3:0]=5 → digit 2 shows 0010010.
6. Assert rst for 1 cycle mid-scan with w=1 → next cycle all outputs at reset values; after release, scan restarts at an=1110 with w=0.
